cpu_speed_sequencer: RTL
========================

Name: cpu_speed_sequencer

Overview:
- Sequences changes to the 2-bit cpu_speed select that drives the two-level glitch-free CPU clock mux: 3.5/7 MHz in one first-stage pair, 14/28 MHz in the other, and a second stage choosing between the pairs.
- Accepts speed requests from the NextREG write path and waits for a CPU-safe point.
- Changes the first-stage select bit before the second-stage bit, with a settle interval after each, so no mux stage switches while its inputs are mid-switch.
- Sits between the NextREG decoder and the system clock block, in the 28 MHz domain.

Parameters:
SETTLE_CYCLES, 32, clk_28 cycles held after each select-bit change; must cover switchover time at the slowest input clock (3.5 MHz = 8 clk_28 periods; 32 gives 4 periods).
DWELL_CYCLES, 16, minimum clk_28 cycles in DWELL after a sequence before a pending request starts.

Ports:
clk_28  input  1  28 MHz system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
speed_req  input  2  requested speed: 00 = 3.5 MHz, 01 = 7 MHz, 10 = 14 MHz, 11 = 28 MHz.
speed_wr  input  1  one-cycle strobe; speed_req is valid in this cycle.
cpu_safe  input  1  high when the CPU is at a safe switch point (between M-cycles, no contention).
cpu_speed  output  2  select to the clock block; bit0 = first-stage select, bit1 = second-stage select.
busy  output  1  high from acceptance of a request until the sequence and dwell complete.
done  output  1  one-cycle pulse when cpu_speed equals the target and settle is complete.
pending  output  1  high while a request is latched but not yet started.

Behaviour:
- Reset, synchronous, applied on the next edge even mid-sequence: cpu_speed = 00, busy = 0, done = 0, pending = 0, state = IDLE, counters = 0, pending request cleared.
- Request latch: speed_wr stores speed_req into pend_val and sets pending, in any state. Latest write wins. A write coincident with the end of DWELL is still latched and is started on the next pass through IDLE.
- States and transitions:
  - IDLE: if pending, clear pending, load target = pend_val, go to CHECK. Otherwise stay.
  - CHECK: if target == cpu_speed, pulse done next cycle and return to IDLE; no settle, no dwell. Otherwise assert busy and go to WAIT_SAFE.
  - WAIT_SAFE: wait for cpu_safe = 1; the cycle that samples 1 moves to STEP_LO. There is no timeout.
  - STEP_LO: if target[0] != cpu_speed[0], write cpu_speed[0] = target[0], clear the counter, go to SETTLE_LO. Otherwise go directly to STEP_HI.
  - SETTLE_LO: count to SETTLE_CYCLES-1, then go to STEP_HI.
  - STEP_HI: if target[1] != cpu_speed[1], write cpu_speed[1], clear the counter, go to SETTLE_HI. Otherwise go to DWELL.
  - SETTLE_HI: count to SETTLE_CYCLES-1, then go to DWELL.
  - DWELL: on entry, done pulses for 1 cycle. Count DWELL_CYCLES, then deassert busy and go to IDLE.
- Ordering: only one cpu_speed bit changes per edge. bit0 always changes before bit1.
- Timing: CHECK to cpu_speed[0] change = 2 cycles when cpu_safe is already high.
- busy timing: asserts on the cycle after CHECK and stays high through the final DWELL cycle.
- cpu_speed is registered and changes only in STEP_LO and STEP_HI.
- A pending request never preempts a running sequence.
- Counter width = clog2(max(SETTLE_CYCLES, DWELL_CYCLES)) + 1. The counter saturates; no wrap-around.
- Parameter check: SETTLE_CYCLES and DWELL_CYCLES must be >= 1; elaboration fails otherwise.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - speed encodings SPEED_3M5 = 2'b00, SPEED_7 = 2'b01, SPEED_14 = 2'b10, SPEED_28 = 2'b11;
  - the state enum (IDLE, CHECK, WAIT_SAFE, STEP_LO, SETTLE_LO, STEP_HI, SETTLE_HI, DWELL);
  - default SETTLE/DWELL constants.
- One sub-module, seq_interval_timer: a load/start, count-to-N, terminal-pulse timer, shared by the SETTLE and DWELL states.

Test Plan:
- Reset, then speed_wr with 11 and cpu_safe = 1:
  - cpu_speed goes 00 → 01 two cycles after CHECK;
  - 01 → 11 exactly 32 cycles later;
  - done pulses on DWELL entry;
  - busy falls 16 cycles after that.
- Request 10 from 11:
  - only bit0 changes, 11 → 10;
  - STEP_HI skips settle, so total busy = 1 + 32 + 16 cycles plus the safe wait.
- Request with cpu_safe = 0 for 100 cycles:
  - cpu_speed is unchanged throughout and busy stays high;
  - the first bit change occurs 1 cycle after cpu_safe rises.
- During SETTLE_LO, write 01 then 10 on consecutive cycles:
  - pending is set and pend_val = 10;
  - the current sequence completes;
  - the 10 sequence starts after DWELL.
- Request equal to current speed (01 → 01): done pulses 2 cycles after speed_wr; busy stays 0; cpu_speed is unchanged.
- Assert reset in SETTLE_HI: the next edge gives cpu_speed = 00, busy = 0, pending = 0, and no done pulse follows.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock speed sequencer: speed encodings,
// sequencer state codes and default interval lengths.
package cpu_clk_pkg;

  localparam logic [1:0] SPEED_3M5 = 2'b00;
  localparam logic [1:0] SPEED_7   = 2'b01;
  localparam logic [1:0] SPEED_14  = 2'b10;
  localparam logic [1:0] SPEED_28  = 2'b11;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_CHECK     = 3'd1;
  localparam seq_state_t ST_WAIT_SAFE = 3'd2;
  localparam seq_state_t ST_STEP_LO   = 3'd3;
  localparam seq_state_t ST_SETTLE_LO = 3'd4;
  localparam seq_state_t ST_STEP_HI   = 3'd5;
  localparam seq_state_t ST_SETTLE_HI = 3'd6;
  localparam seq_state_t ST_DWELL     = 3'd7;

  localparam int SETTLE_CYCLES_DEF = 32;
  localparam int DWELL_CYCLES_DEF  = 16;

  // Interval counter width: wide enough to hold the longer interval itself.
  function automatic int seq_cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/cpu_speed_sequencer_if.sv
// Request/status bundle between the NextREG write path and the speed sequencer.
interface cpu_speed_sequencer_if;
  logic [1:0] speed_req;
  logic       speed_wr;
  logic       cpu_safe;
  logic [1:0] cpu_speed;
  logic       busy;
  logic       done;
  logic       pending;

  modport master (
    output speed_req, speed_wr, cpu_safe,
    input  cpu_speed, busy, done, pending
  );

  modport slave (
    input  speed_req, speed_wr, cpu_safe,
    output cpu_speed, busy, done, pending
  );
endinterface

// File: rtl/seq_interval_timer.sv
// Saturating interval counter shared by the settle and dwell phases; term is
// high once the count has reached limit.
module seq_interval_timer #(
  parameter int CW = 6
) (
  input  logic          clk_28,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] limit,
  output logic          term
);

  logic [CW-1:0] cnt_d, cnt_q;

  // Start loads 1: the cycle that launches an interval is counted as its first.
  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = CW'(1);
    else if (cnt_q != {CW{1'b1}})
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_28) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign term = (cnt_q >= limit);

endmodule

// File: rtl/cpu_speed_sequencer.sv
// Steps the two-level CPU clock mux select one bit at a time (first stage,
// then second), holding each change for a settle interval, then dwells.
module cpu_speed_sequencer
  import cpu_clk_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DWELL_CYCLES  = DWELL_CYCLES_DEF
) (
  input logic                  clk_28,
  input logic                  reset,
  cpu_speed_sequencer_if.slave bus
);

  if (SETTLE_CYCLES < 1 || DWELL_CYCLES < 1) begin : g_param_chk
    $error("cpu_speed_sequencer: SETTLE_CYCLES and DWELL_CYCLES must be >= 1");
  end

  localparam int CW = seq_cnt_width(SETTLE_CYCLES, DWELL_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES);

  seq_state_t    state_d, state_q;
  logic [1:0]    speed_d, speed_q;
  logic [1:0]    target_d, target_q;
  logic [1:0]    pend_val_d, pend_val_q;
  logic          pending_d, pending_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          consume;
  logic          tmr_start, tmr_term;
  logic [CW-1:0] tmr_limit;

  seq_interval_timer #(.CW(CW)) u_timer (
    .clk_28 (clk_28),
    .reset  (reset),
    .start  (tmr_start),
    .limit  (tmr_limit),
    .term   (tmr_term)
  );

  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    target_d  = target_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    consume   = 1'b0;
    tmr_start = 1'b0;
    tmr_limit = SETTLE_LAST;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          consume  = 1'b1;
          target_d = pend_val_q;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (target_q == speed_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_WAIT_SAFE;
        end
      end
      ST_WAIT_SAFE: begin
        if (bus.cpu_safe) state_d = ST_STEP_LO;
      end
      ST_STEP_LO: begin
        if (target_q[0] != speed_q[0]) begin
          speed_d[0] = target_q[0];
          tmr_start  = 1'b1;
          state_d    = ST_SETTLE_LO;
        end else begin
          state_d = ST_STEP_HI;
        end
      end
      ST_SETTLE_LO: begin
        if (tmr_term) state_d = ST_STEP_HI;
      end
      ST_STEP_HI: begin
        tmr_start = 1'b1;
        if (target_q[1] != speed_q[1]) begin
          speed_d[1] = target_q[1];
          state_d    = ST_SETTLE_HI;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DWELL;
        end
      end
      ST_SETTLE_HI: begin
        if (tmr_term) begin
          tmr_start = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DWELL;
        end
      end
      ST_DWELL: begin
        tmr_limit = DWELL_LAST;
        if (tmr_term) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new write always wins over IDLE consuming the previous one.
  always_comb begin
    pend_val_d = bus.speed_wr ? bus.speed_req : pend_val_q;
    pending_d  = bus.speed_wr | (pending_q & ~consume);
  end

  always_ff @(posedge clk_28) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      speed_q    <= SPEED_3M5;
      target_q   <= SPEED_3M5;
      pend_val_q <= SPEED_3M5;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      target_q   <= target_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.cpu_speed = speed_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pending   = pending_q;

endmodule
